// File: rtl/mb32_mul_arbiter.sv
// Round-robin front end that shares one pipelined Booth multiplier among NREQ requesters.
// Tags ride alongside the datapath so each product lands in its requester's one-entry buffer.

module mb32_rsp_slot #(
    parameter int W2 = 64
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          grant,
    input  logic          fill,
    input  logic [W2-1:0] fill_product,
    input  logic          rsp_ready,
    output logic          slot_busy,
    output logic          rsp_valid,
    output logic [W2-1:0] rsp_product
);
    // slot_busy spans grant through response handshake, so one pair per requester at most
    always_ff @(posedge CLK) begin
        if (RST) begin
            slot_busy   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_product <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                slot_busy <= 1'b0;
                rsp_valid <= 1'b0;
            end
            if (grant)
                slot_busy <= 1'b1;
            if (fill) begin
                rsp_valid   <= 1'b1;
                rsp_product <= fill_product;
            end
        end
    end
endmodule

module mb32_mul_arbiter #(
    parameter int WIDTH    = 32,
    parameter int NREQ     = 4,
    parameter int PIPE_LAT = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [NREQ*2*WIDTH-1:0]   rsp_product,
    output logic                      mul_issue,
    output logic [WIDTH-1:0]          mul_a,
    output logic [WIDTH-1:0]          mul_b,
    input  logic [2*WIDTH-1:0]        mul_product,
    output logic                      busy
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0]              rr_ptr, gnt_id, idx;
    logic                        gnt_any;
    logic [NREQ-1:0]             gnt, eligible, slot_busy, fill;
    logic [WIDTH-1:0]            a_arr [NREQ];
    logic [WIDTH-1:0]            b_arr [NREQ];
    logic [PIPE_LAT:1]           vld_pipe;
    logic [PIPE_LAT:1][IDW-1:0]  id_pipe;

    assign eligible = req_valid & ~slot_busy;

    // first eligible requester at or after rr_ptr wins; nothing is granted during reset
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!gnt_any && eligible[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
        if (RST) begin
            gnt     = '0;
            gnt_id  = '0;
            gnt_any = 1'b0;
        end
    end

    assign req_ready = gnt;
    assign mul_issue = gnt_any;
    assign mul_a     = gnt_any ? a_arr[gnt_id] : '0;
    assign mul_b     = gnt_any ? b_arr[gnt_id] : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr   <= '0;
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            if (gnt_any)
                rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
            vld_pipe[1] <= gnt_any;
            id_pipe[1]  <= gnt_id;
            for (int s = 2; s <= PIPE_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
        end
    end

    // the tail tag lines up with the product leaving the datapath this cycle
    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
        assign fill[i]  = vld_pipe[PIPE_LAT] && (id_pipe[PIPE_LAT] == IDW'(i));

        mb32_rsp_slot #(.W2(2*WIDTH)) u_slot (
            .CLK          (CLK),
            .RST          (RST),
            .grant        (gnt[i]),
            .fill         (fill[i]),
            .fill_product (mul_product),
            .rsp_ready    (rsp_ready[i]),
            .slot_busy    (slot_busy[i]),
            .rsp_valid    (rsp_valid[i]),
            .rsp_product  (rsp_product[i*2*WIDTH +: 2*WIDTH])
        );
    end

    assign busy = !RST && ((|vld_pipe) || (|rsp_valid));
endmodule

// File: tb/tb_mb32_mul_arbiter.sv
// Bench for mb32_mul_arbiter: delayed signed-multiply datapath, queue-based reference
// model checked every cycle, plus a vector table and directed corner sequences.

module tb_mb32_mul_arbiter;
    localparam int WIDTH    = 32;
    localparam int NREQ     = 4;
    localparam int PIPE_LAT = 2;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic [NREQ-1:0]         req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*WIDTH-1:0]   req_a, req_b;
    logic [NREQ*2*WIDTH-1:0] rsp_product;
    logic                    mul_issue, busy;
    logic [WIDTH-1:0]        mul_a, mul_b;
    logic [2*WIDTH-1:0]      mul_product;

    mb32_mul_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .PIPE_LAT(PIPE_LAT)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_product(rsp_product), .mul_issue(mul_issue), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // datapath stand-in: signed product appears PIPE_LAT cycles after issue, junk otherwise
    logic [2*WIDTH-1:0] dp [PIPE_LAT];
    always @(posedge CLK) begin
        dp[0] <= mul_issue ? 64'(longint'($signed(mul_a)) * longint'($signed(mul_b)))
                           : 64'hBAD0_BAD0_BAD0_BAD0;
        for (int s = 1; s < PIPE_LAT; s++) dp[s] <= dp[s-1];
    end
    assign mul_product = dp[PIPE_LAT-1];

    typedef struct { int id; logic [63:0] p; int due; } fl_t;
    typedef struct { int id; logic [31:0] a; logic [31:0] b; logic [63:0] p; } vec_t;

    int          mptr, mcyc, npass, ntot, last_gnt, obs_cyc;
    bit          mslot [NREQ];
    bit          mbv   [NREQ];
    logic [63:0] mbp   [NREQ];
    fl_t         fl [$];
    bit          auto_drop;
    logic [NREQ-1:0]         obs_rv;
    logic [NREQ*2*WIDTH-1:0] obs_prod;
    logic                    obs_busy;

    function automatic logic [63:0] ref_mul(logic [31:0] a, logic [31:0] b);
        return 64'(longint'($signed(a)) * longint'($signed(b)));
    endfunction

    function automatic logic [WIDTH-1:0] opnd(logic [NREQ*WIDTH-1:0] v, int i);
        return v[i*WIDTH +: WIDTH];
    endfunction

    function automatic logic [63:0] pslice(logic [NREQ*2*WIDTH-1:0] v, int i);
        return v[i*2*WIDTH +: 2*WIDTH];
    endfunction

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, mcyc);
    endtask

    task automatic model_reset();
        mptr = 0;
        for (int i = 0; i < NREQ; i++) begin mslot[i] = 0; mbv[i] = 0; mbp[i] = '0; end
        fl.delete();
    endtask

    // called at a negedge with inputs already driven; returns at the next negedge
    task automatic cycle();
        int g;
        logic [NREQ-1:0] erdy, ev, hs;
        logic [NREQ*2*WIDTH-1:0] eprod;
        logic [WIDTH-1:0] ea, eb;
        #1;
        g = -1;
        if (!RST)
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (mptr + k) % NREQ;
                if (g < 0 && req_valid[i] && !mslot[i]) g = i;
            end
        erdy = (g >= 0) ? NREQ'(1) << g : '0;
        ea = (g >= 0) ? opnd(req_a, g) : '0;
        eb = (g >= 0) ? opnd(req_b, g) : '0;
        for (int i = 0; i < NREQ; i++) begin
            ev[i] = mbv[i];
            eprod[i*2*WIDTH +: 2*WIDTH] = mbp[i];
        end
        chk("req_ready",   256'(req_ready),   256'(erdy));
        chk("mul_issue",   256'(mul_issue),   256'(g >= 0));
        chk("mul_a",       256'(mul_a),       256'(ea));
        chk("mul_b",       256'(mul_b),       256'(eb));
        chk("rsp_valid",   256'(rsp_valid),   256'(ev));
        chk("rsp_product", 256'(rsp_product), 256'(eprod));
        chk("busy",        256'(busy),        256'(!RST && (fl.size() > 0 || ev != '0)));
        last_gnt = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) last_gnt = i;
        obs_rv = rsp_valid; obs_prod = rsp_product; obs_busy = busy; obs_cyc = mcyc;
        hs = req_valid & req_ready;
        @(posedge CLK);
        if (RST) model_reset();
        else begin
            for (int i = 0; i < NREQ; i++)
                if (mbv[i] && rsp_ready[i]) begin mbv[i] = 0; mslot[i] = 0; end
            for (int j = fl.size() - 1; j >= 0; j--)
                if (fl[j].due == mcyc) begin
                    mbv[fl[j].id] = 1; mbp[fl[j].id] = fl[j].p; fl.delete(j);
                end
            if (g >= 0) begin
                mslot[g] = 1;
                fl.push_back('{g, ref_mul(opnd(req_a, g), opnd(req_b, g)), mcyc + PIPE_LAT});
                mptr = (g + 1) % NREQ;
            end
        end
        mcyc++;
        @(negedge CLK);
        if (auto_drop) req_valid = req_valid & ~hs;
    endtask

    task automatic idle(int n);
        repeat (n) cycle();
    endtask

    task automatic set_req(int id, logic [31:0] a, logic [31:0] b);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        req_valid = req_valid | (NREQ'(1) << id);
    endtask

    // handshake-to-rsp_valid latency in cycles; -1 on timeout
    task automatic wait_rsp(int id, output int lat, output logic [63:0] prod);
        int hsc;
        hsc = -1; lat = -1; prod = '0;
        for (int n = 0; n < 30; n++) begin
            cycle();
            if (hsc < 0) begin
                if (last_gnt == id) hsc = obs_cyc;
            end else if (obs_rv[id]) begin
                lat = obs_cyc - hsc; prod = pslice(obs_prod, id); break;
            end
        end
    endtask

    initial begin
        vec_t vt [6];
        int lat, cnt2, hsc;
        logic [63:0] prod, p1;
        logic [63:0] t3_exp [NREQ];

        vt[0] = '{0, 32'd3,          32'd5,          64'd15};
        vt[1] = '{0, 32'hFFFF_FFFF,  32'd2,          64'hFFFF_FFFF_FFFF_FFFE};
        vt[2] = '{1, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
        vt[3] = '{2, 32'h7FFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFF_8000_0001};
        vt[4] = '{3, 32'd0,          32'h1234_5678,  64'd0};
        vt[5] = '{3, 32'h0000_FFFF,  32'h0001_0001,  64'h0000_0000_FFFF_FFFF};
        t3_exp = '{64'd200, 64'd303, 64'd408, 64'd515};

        npass = 0; ntot = 0; mcyc = 0; auto_drop = 1;
        RST = 1'b1; req_valid = '0; rsp_ready = '1; req_a = '0; req_b = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        model_reset();
        set_req(0, 32'd9, 32'd9);
        idle(2);
        chk("rst_no_grant", 256'(last_gnt == -1), 256'(1));
        RST = 1'b0; req_valid = '0;
        idle(2);

        for (int v = 0; v < 6; v++) begin
            set_req(vt[v].id, vt[v].a, vt[v].b);
            wait_rsp(vt[v].id, lat, prod);
            chk("tbl_latency", 256'(lat),  256'(PIPE_LAT + 1));
            chk("tbl_product", 256'(prod), 256'(vt[v].p));
            idle(2);
        end

        // all four at once: consecutive grants 0..3, products held in their own slots
        rsp_ready = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 2), 32'(100 + i));
        for (int k = 0; k < NREQ; k++) begin
            cycle();
            chk("t3_grant_order", 256'(last_gnt), 256'(k));
        end
        idle(4);
        chk("t3_all_valid", 256'(obs_rv), 256'({NREQ{1'b1}}));
        for (int i = 0; i < NREQ; i++) chk("t3_slot_product", 256'(pslice(obs_prod, i)), 256'(t3_exp[i]));
        rsp_ready = '1;
        idle(3);

        // pointer wrap: park rr_ptr at 3, then 3 and 0 compete
        set_req(2, 32'd11, 32'd13);
        wait_rsp(2, lat, prod);
        idle(2);
        set_req(3, 32'd21, 32'd2);
        set_req(0, 32'd4,  32'hFFFF_FFFC);
        cycle();
        chk("t4_grant3", 256'(last_gnt), 256'(3));
        cycle();
        chk("t4_wrap0", 256'(last_gnt), 256'(0));
        idle(5);

        // back-pressure on requester 1 while requester 2 keeps streaming
        auto_drop = 0;
        rsp_ready[1] = 1'b0;
        set_req(1, 32'd1234, 32'hFFFF_FFFD);
        set_req(2, 32'd77,   32'd3);
        p1 = ref_mul(32'd1234, 32'hFFFF_FFFD);
        for (int n = 0; n < 10; n++) begin
            cycle();
            if (obs_rv[1]) break;
        end
        chk("t5_rsp1_arrived", 256'(obs_rv[1]), 256'(1));
        cnt2 = 0;
        for (int n = 0; n < 10; n++) begin
            cycle();
            chk("t5_no_grant1", 256'(last_gnt == 1), 256'(0));
            chk("t5_held_valid", 256'(obs_rv[1]), 256'(1));
            chk("t5_held_product", 256'(pslice(obs_prod, 1)), 256'(p1));
            if (last_gnt == 2) cnt2++;
        end
        chk("t5_req2_progress", 256'(cnt2 >= 2), 256'(1));
        rsp_ready[1] = 1'b1;
        cycle();
        cycle();
        chk("t5_regrant1", 256'(last_gnt), 256'(1));
        req_valid = '0; auto_drop = 1;
        idle(8);

        // reset with two pairs in flight
        set_req(0, 32'd5, 32'd6);
        set_req(1, 32'd7, 32'd8);
        idle(2);
        chk("t6_busy_before", 256'(obs_busy), 256'(1));
        RST = 1'b1; req_valid = '0;
        cycle();
        RST = 1'b0;
        for (int n = 0; n < 5; n++) begin
            cycle();
            chk("t6_no_rsp", 256'(obs_rv), 256'(0));
            chk("t6_idle", 256'(obs_busy), 256'(0));
        end
        set_req(3, 32'd2, 32'd2);
        set_req(0, 32'hFFFF_FFF0, 32'd16);
        cycle();
        chk("t6_ptr_zero", 256'(last_gnt), 256'(0));
        hsc = obs_cyc; lat = -1;
        for (int n = 0; n < 10; n++) begin
            cycle();
            if (obs_rv[0]) begin lat = obs_cyc - hsc; break; end
        end
        chk("t6_latency", 256'(lat), 256'(PIPE_LAT + 1));
        chk("t6_product", 256'(pslice(obs_prod, 0)), 256'(64'hFFFF_FFFF_FFFF_FF00));
        idle(6);

        // random traffic with random back-pressure and occasional reset
        auto_drop = 0;
        for (int n = 0; n < 800; n++) begin
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                req_a[i*WIDTH +: WIDTH] = $urandom;
                req_b[i*WIDTH +: WIDTH] = $urandom;
                rsp_ready[i] = ($urandom_range(0, 9) < 7);
            end
            RST = ($urandom_range(0, 99) == 0);
            cycle();
        end
        RST = 1'b0; req_valid = '0; rsp_ready = '1;
        idle(8);
        chk("drain_idle", 256'(obs_busy), 256'(0));

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
